// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter and the
// sequence-detector tests that consume its stream.
package seq_pattern_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_LEN_W = 5;
  localparam int unsigned DEF_REP_W = 4;

  // Target sequence of the downstream sequence detector
  localparam int unsigned    DET_LEN = 4;
  localparam logic [DET_LEN-1:0] DET_SEQ = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel frame and shifts it out
// MSB-first, repeated back-to-back, one bit per clock.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_reps,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               load_ready_q, load_ready_d;

  logic               accept;
  logic               len_ok;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    len_d        = len_q;
    bit_idx_d    = bit_idx_q;
    rep_cnt_d    = rep_cnt_q;
    out_d        = 1'b0;
    out_valid_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    load_ready_d = 1'b0;

    accept = load_valid && load_ready_q;
    len_ok = (load_len != '0) && (load_len <= LEN_W'(WIDTH));

    case (state_q)
      ST_IDLE: begin
        if (accept && len_ok) begin
          data_d    = load_data;
          len_d     = load_len;
          bit_idx_d = IDX_W'(load_len - 1'b1);
          rep_cnt_d = load_reps;
          state_d   = ST_SHIFT;
        end
        err_d = accept && !len_ok;
      end
      ST_SHIFT: begin
        out_valid_d = !abort;
        out_d       = !abort && data_q[bit_idx_q];
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - 1'b1;
        end else if (rep_cnt_q != '0) begin
          rep_cnt_d = rep_cnt_q - 1'b1;
          bit_idx_d = IDX_W'(len_q - 1'b1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = out_valid_d || (state_q == ST_DONE);
    // Ready only once the FSM has sat in IDLE for a full cycle
    load_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      len_q        <= '0;
      bit_idx_q    <= '0;
      rep_cnt_q    <= '0;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      len_q        <= len_d;
      bit_idx_q    <= bit_idx_d;
      rep_cnt_q    <= rep_cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign load_ready = load_ready_q;

endmodule
